// File: rtl/ioctl_sdram_bridge.sv
// Packs ioctl download bytes into 16-bit SDRAM words and issues them on a toggle req/ack port.
// Optional ROM_CHECKSUM_EN adds a 16-bit running byte checksum output.
`timescale 1ns/1ps
module ioctl_sdram_bridge #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              port_req,
    input  logic              port_ack,
    output logic [ADDR_W-1:0] port_a,
    output logic [1:0]        port_ds,
    output logic              port_we,
    output logic [15:0]       port_d,
    output logic              busy,
    output logic              overflow
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);
    localparam int EW = ADDR_W + 18;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic          wr_last, dl_last;
    logic          pend_v;
    logic [23:0]   pend_wa;
    logic [7:0]    pend_d;
    logic          s0_v, s1_v;
    logic [EW-1:0] s0, s1;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [1:0]    state;

    logic          capture, dl_fall, empty, full, push, pop;
    logic          e0_v, e1_v, pend_v_n;
    logic [EW-1:0] e0, e1, flush_e, odd_e, head;
    logic [23:0]   pend_wa_n;
    logic [7:0]    pend_d_n;

    assign capture = ioctl_wr & ~wr_last & ioctl_download;
    assign dl_fall = dl_last & ~ioctl_download;
    assign flush_e = {pend_wa[ADDR_W-1:0], 2'b01, pend_d, pend_d};
    assign odd_e   = {ioctl_addr[ADDR_W:1], 2'b10, ioctl_dout, ioctl_dout};

    // The pending register only ever holds an even byte; odd bytes either pair with it or go out alone.
    always_comb begin
        e0_v      = 1'b0;
        e1_v      = 1'b0;
        e0        = '0;
        e1        = '0;
        pend_v_n  = pend_v;
        pend_wa_n = pend_wa;
        pend_d_n  = pend_d;
        if (capture) begin
            if (!ioctl_addr[0]) begin
                if (pend_v) begin
                    e0_v = 1'b1;
                    e0   = flush_e;
                end
                pend_v_n  = 1'b1;
                pend_wa_n = ioctl_addr[24:1];
                pend_d_n  = ioctl_dout;
            end else if (pend_v && (pend_wa == ioctl_addr[24:1])) begin
                e0_v     = 1'b1;
                e0       = {ioctl_addr[ADDR_W:1], 2'b11, ioctl_dout, pend_d};
                pend_v_n = 1'b0;
            end else begin
                e0_v     = 1'b1;
                e0       = pend_v ? flush_e : odd_e;
                e1_v     = pend_v;
                e1       = odd_e;
                pend_v_n = 1'b0;
            end
        end else if (dl_fall && pend_v) begin
            e0_v     = 1'b1;
            e0       = flush_e;
            pend_v_n = 1'b0;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = s0_v & ~full;
    assign head  = mem[rd_ptr[PW-1:0]];
    assign pop   = ~empty & ((state == IDLE) | ((state == WAIT) & (port_ack == port_req)));

    // Staging slot s0 is written to the FIFO every cycle it is valid; s1 holds the second
    // entry of a two-entry byte so it lands one cycle later.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_last  <= 1'b0;
            dl_last  <= 1'b0;
            pend_v   <= 1'b0;
            pend_wa  <= '0;
            pend_d   <= '0;
            s0_v     <= 1'b0;
            s1_v     <= 1'b0;
            s0       <= '0;
            s1       <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_last <= ioctl_wr;
            dl_last <= ioctl_download;
            pend_v  <= pend_v_n;
            pend_wa <= pend_wa_n;
            pend_d  <= pend_d_n;
            if (s1_v) begin
                s0_v <= 1'b1;
                s0   <= s1;
                s1_v <= e0_v;
                s1   <= e0;
            end else begin
                s0_v <= e0_v;
                s0   <= e0;
                s1_v <= e1_v;
                s1   <= e1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (s0_v && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr[PW-1:0]] <= s0;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            port_req <= 1'b0;
            port_we  <= 1'b0;
            port_a   <= '0;
            port_ds  <= '0;
            port_d   <= '0;
            rd_ptr   <= '0;
        end else begin
            case (state)
                SYNC: begin
                    port_req <= port_ack;
                    state    <= IDLE;
                end
                IDLE: if (pop) state <= WAIT;
                WAIT: begin
                    if (port_ack == port_req) begin
                        port_we <= 1'b0;
                        if (!pop) state <= IDLE;
                    end
                end
                default: state <= SYNC;
            endcase
            if (pop) begin
                port_a   <= head[EW-1:18];
                port_ds  <= head[17:16];
                port_d   <= head[15:0];
                port_we  <= 1'b1;
                port_req <= ~port_req;
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

    assign busy = (state == SYNC) | ioctl_download | pend_v | s0_v | s1_v | ~empty
                | (port_req != port_ack);

`ifdef ROM_CHECKSUM_EN
    logic       cap_v;
    logic [7:0] cap_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cap_v    <= 1'b0;
            cap_d    <= '0;
            checksum <= '0;
        end else begin
            cap_v <= capture;
            cap_d <= ioctl_dout;
            if (ioctl_download && !dl_last) checksum <= '0;
            else if (cap_v) checksum <= checksum + {8'h00, cap_d};
        end
    end
`endif

endmodule
